// File: rtl/vending_input_conditioner.sv
// Front-panel input conditioner: synchronises, debounces and edge-detects the
// active-low buttons and the active-high collect confirmation for the vending FSM.
`timescale 1ns/1ps
module vending_input_conditioner #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn,
  input  logic               collected,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic               collected_level,
  output logic               collected_pulse
);

  localparam int NCH   = NUM_BTN + 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Pin-level idle pattern: buttons idle high, collected idles low.
  localparam logic [NCH-1:0]   IDLE     = {1'b0, {NUM_BTN{1'b1}}};

  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync_p0;
  logic [NCH-1:0] sync_p1;
  logic [NCH-1:0] active_p1;
  logic [NCH-1:0] stable_p2;
  logic [NCH-1:0] pulse_p2;

  assign raw = {collected, btn};

  // Stage 0/1: two-flop synchroniser, held at the idle pin level in reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= IDLE;
      sync_p1 <= IDLE;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  assign active_p1 = sync_p1 ^ IDLE;

  // Stage 2: per-channel debounce counter, accepted level and press strobe
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic             stable;
    logic             pulse;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        stable <= 1'b0;
        pulse  <= 1'b0;
        cnt    <= '0;
      end else begin
        pulse <= 1'b0;
        if (active_p1[i] == stable) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          stable <= ~stable;
          pulse  <= ~stable;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end
    end

    assign stable_p2[i] = stable;
    assign pulse_p2[i]  = pulse;
  end

  assign btn_level       = stable_p2[NUM_BTN-1:0];
  assign btn_pulse       = pulse_p2[NUM_BTN-1:0];
  assign collected_level = stable_p2[NUM_BTN];
  assign collected_pulse = pulse_p2[NUM_BTN];

endmodule
